// File: rtl/loss_pkg.sv
// Shared definitions for the loss accumulator slice: default widths,
// the vector result bundle and the result-register state encoding used
// when the mean output (LOSS_ACC_MEAN_EN) is built in.
package loss_pkg;

    localparam int LOSS_ACC_W_DEF = 48;
    localparam int LOSS_CNT_W_DEF = 16;

    // Widest supported configuration; the result bundle is sized for it
    // and each instance uses only its low ACC_W / CNT_W bits.
    localparam int LOSS_ACC_W_MAX = 64;
    localparam int LOSS_CNT_W_MAX = 32;

    typedef struct packed {
        logic [LOSS_ACC_W_MAX-1:0] sum;
        logic [LOSS_CNT_W_MAX-1:0] count;
        logic                      sat;
    } loss_result_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_DIVIDE,
        DIV_HOLD
    } div_state_t;

endpackage

// File: rtl/loss_divider.sv
// Sequential restoring divider: one quotient bit per cycle, ACC_W cycles
// from start to done. Only built when LOSS_ACC_MEAN_EN is defined.
`ifdef LOSS_ACC_MEAN_EN
module loss_divider
    import loss_pkg::*;
#(
    parameter int ACC_W = LOSS_ACC_W_DEF,
    parameter int CNT_W = LOSS_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [ACC_W-1:0] quotient,
    output logic             done
);

    localparam int STEP_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0]  quo;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  div_q;
    logic [STEP_W-1:0] steps;
    logic              running;
    logic [CNT_W:0]    trial;
    logic              fits;

    // Trial subtraction for the next quotient bit.
    always_comb begin
        trial = {rem, quo[ACC_W-1]};
        fits  = (trial >= {1'b0, div_q});
    end

    // Shift dividend bits out of quo while quotient bits shift in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo     <= '0;
            rem     <= '0;
            div_q   <= '0;
            steps   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo     <= dividend;
                rem     <= '0;
                div_q   <= divisor;
                steps   <= STEP_W'(ACC_W);
                running <= 1'b1;
            end else if (running) begin
                quo   <= {quo[ACC_W-2:0], fits};
                rem   <= fits ? CNT_W'(trial - {1'b0, div_q}) : trial[CNT_W-1:0];
                steps <= steps - STEP_W'(1);
                if (steps == STEP_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule
`endif

// File: rtl/loss_accumulator.sv
// Vector loss accumulator: sums the per-element loss stream until last_in,
// then offers {sum, count, sat} on a valid/ready result register. The input
// is never backpressured; a result that finds the register occupied is
// dropped and flagged on the sticky overrun output.
// Optional feature macro: LOSS_ACC_MEAN_EN adds mean_out = floor(sum/count)
// via a multi-cycle divider, delaying out_valid until the divide finishes.
module loss_accumulator
    import loss_pkg::*;
#(
    parameter int ACC_W = LOSS_ACC_W_DEF,
    parameter int CNT_W = LOSS_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [31:0]      loss_in,
    input  logic             last_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic [CNT_W-1:0] count_out,
    output logic             sat_out,
    output logic             overrun,
    output logic             busy
`ifdef LOSS_ACC_MEAN_EN
    ,
    output logic [ACC_W-1:0] mean_out
`endif
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W:0]   acc_sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             acc_ovf;
    logic             cnt_ovf;
    logic             close;
    loss_result_t     result_q;
    loss_result_t     result_nxt;
    logic             unused_result_hi;

    // Saturating add of the zero-extended element and saturating count.
    always_comb begin
        acc_sum = {1'b0, acc} + (ACC_W + 1)'(loss_in);
        acc_ovf = acc_sum[ACC_W];
        acc_nxt = acc_ovf ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        cnt_ovf = &cnt;
        cnt_nxt = cnt_ovf ? cnt : cnt + CNT_W'(1);
        sat_nxt = sat | acc_ovf | cnt_ovf;
        close   = valid_in & last_in;
        result_nxt       = '0;
        result_nxt.sum   = LOSS_ACC_W_MAX'(acc_nxt);
        result_nxt.count = LOSS_CNT_W_MAX'(cnt_nxt);
        result_nxt.sat   = sat_nxt;
    end

    // Running vector state; a close restarts it so the next element begins a new vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (clear || close) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (valid_in) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            sat <= sat_nxt;
        end
    end

`ifdef LOSS_ACC_MEAN_EN

    div_state_t       state;
    div_state_t       state_nxt;
    logic             capture;
    logic             set_overrun;
    logic             div_done;
    logic [ACC_W-1:0] quotient;

    // Result-register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a close starts a divide, done exposes it, handshake releases it.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE:   if (close) state_nxt = DIV_DIVIDE;
            DIV_DIVIDE: if (div_done) state_nxt = DIV_HOLD;
            DIV_HOLD:   if (out_ready) state_nxt = close ? DIV_DIVIDE : DIV_IDLE;
            default:    state_nxt = DIV_IDLE;
        endcase
        if (clear) state_nxt = DIV_IDLE;
    end

    // Decode whether this cycle's close is accepted or lost.
    always_comb begin
        capture     = 1'b0;
        set_overrun = 1'b0;
        if (!clear && close) begin
            capture     = (state == DIV_IDLE) || (state == DIV_HOLD && out_ready);
            set_overrun = !capture;
        end
    end

    // Captured result and sticky overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            overrun  <= 1'b0;
        end else if (clear) begin
            overrun <= 1'b0;
        end else begin
            if (capture) result_q <= result_nxt;
            if (set_overrun) overrun <= 1'b1;
        end
    end

    loss_divider #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .abort    (clear),
        .start    (capture),
        .dividend (acc_nxt),
        .divisor  (cnt_nxt),
        .quotient (quotient),
        .done     (div_done)
    );

    assign out_valid = (state == DIV_HOLD);
    assign mean_out  = quotient;

`else

    logic out_valid_q;
    logic slot_free;

    assign slot_free = !out_valid_q || out_ready;

    // One-deep result register: load when free, otherwise drop and flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            overrun     <= 1'b0;
        end else if (clear) begin
            out_valid_q <= 1'b0;
            overrun     <= 1'b0;
        end else if (close && slot_free) begin
            result_q    <= result_nxt;
            out_valid_q <= 1'b1;
        end else if (close) begin
            overrun <= 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;

`endif

    assign sum_out          = result_q.sum[ACC_W-1:0];
    assign count_out        = result_q.count[CNT_W-1:0];
    assign sat_out          = result_q.sat;
    assign busy             = (cnt != '0);
    assign unused_result_hi = ^{result_q.sum >> ACC_W, result_q.count >> CNT_W};

endmodule
